// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock frequency meter: FSM state encoding and default widths.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_COUNT  = 2'd2,
    ST_REPORT = 2'd3
  } meas_state_e;

  localparam int DEF_GATE_W = 16;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer for an asynchronous input followed by a registered
// rising-edge detector: each rising edge of d_async yields one rise_pulse cycle.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise_pulse
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= d_async;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign rise_pulse = rise_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Gated edge counter: counts rising edges of an asynchronous input over a
// programmable number of clk cycles and reports the count with a range check.
module clk_freq_meter
  import clk_meas_pkg::*;
#(
  parameter int GATE_W = DEF_GATE_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              meas_in,
  input  logic              start,
  input  logic              cont,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [CNT_W-1:0]  lim_lo,
  input  logic [CNT_W-1:0]  lim_hi,
  output logic              busy,
  output logic [CNT_W-1:0]  count_o,
  output logic              valid_o,
  output logic              in_range_o,
  output logic              sat_o,
  output meas_state_e       state_o
);

  // Handshake: start is a one-cycle request honoured only in IDLE with a
  // non-zero gate_len; valid_o is a one-cycle pulse with no back-pressure.

  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [GATE_W-1:0] GATE_ONE = GATE_W'(1);

  meas_state_e       state_q;
  logic [GATE_W-1:0] gate_q;
  logic [CNT_W-1:0]  edge_q;
  logic [CNT_W-1:0]  edge_d;
  logic              sat_q;
  logic              sat_d;
  logic [CNT_W-1:0]  lim_lo_q;
  logic [CNT_W-1:0]  lim_hi_q;
  logic [CNT_W-1:0]  count_q;
  logic              valid_q;
  logic              in_range_q;
  logic              sat_out_q;
  logic              in_range_d;
  logic              rise;

  edge_sync u_edge_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .d_async    (meas_in),
    .rise_pulse (rise)
  );

  // Saturating next value of the edge counter for the current cycle's pulse.
  always_comb begin
    edge_d = edge_q;
    sat_d  = sat_q;
    if (rise) begin
      if (edge_q == CNT_MAX) begin
        sat_d = 1'b1;
      end else begin
        edge_d = edge_q + 1'b1;
      end
    end
    in_range_d = (lim_lo_q <= edge_d) && (edge_d <= lim_hi_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gate_q     <= '0;
      edge_q     <= '0;
      sat_q      <= 1'b0;
      lim_lo_q   <= '0;
      lim_hi_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      in_range_q <= 1'b0;
      sat_out_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && (gate_len != '0)) begin
            state_q <= ST_ARM;
          end
        end
        ST_ARM: begin
          gate_q   <= gate_len;
          edge_q   <= '0;
          sat_q    <= 1'b0;
          lim_lo_q <= lim_lo;
          lim_hi_q <= lim_hi;
          // A zero window re-entered through continuous mode cannot be timed.
          state_q  <= (gate_len == '0) ? ST_IDLE : ST_COUNT;
        end
        ST_COUNT: begin
          edge_q <= edge_d;
          sat_q  <= sat_d;
          gate_q <= gate_q - GATE_ONE;
          if (gate_q == GATE_ONE) begin
            state_q    <= ST_REPORT;
            count_q    <= edge_d;
            in_range_q <= in_range_d;
            sat_out_q  <= sat_d;
            valid_q    <= 1'b1;
          end
        end
        ST_REPORT: begin
          state_q <= cont ? ST_ARM : ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign count_o    = count_q;
  assign valid_o    = valid_q;
  assign in_range_o = in_range_q;
  assign sat_o      = sat_out_q;
  assign state_o    = state_q;

endmodule

// File: doc/clk_freq_meter.md
CLK_FREQ_METER -- requirements
Module: clk_freq_meter

Interface
REQ-001 SHALL have parameter GATE_W, default 16, meaning width of the gate-length input and gate counter.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the edge counter and result.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all flops on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-005 SHALL have port meas_in, input, 1, meaning the clock/signal under measurement, asynchronous to clk.
REQ-006 SHALL have port start, input, 1, meaning a one-cycle request to begin a measurement.
REQ-007 SHALL have port cont, input, 1, meaning continuous mode: re-arm automatically after each report.
REQ-008 SHALL have port gate_len, input, GATE_W, meaning the measurement window length in clk cycles.
REQ-009 SHALL have ports lim_lo and lim_hi, input, CNT_W each, meaning the inclusive acceptable count range.
REQ-010 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.
REQ-011 SHALL have port count_o, output, CNT_W, meaning the last completed edge count, held until the next report.
REQ-012 SHALL have port valid_o, output, 1, meaning a one-cycle pulse when count_o updates.
REQ-013 SHALL have port in_range_o, output, 1, meaning lim_lo <= count_o <= lim_hi, registered with count_o.
REQ-014 SHALL have port sat_o, output, 1, meaning the edge counter saturated during the last window.

Function
REQ-015 SHALL pass meas_in through a 2-flop synchronizer, then a registered rising-edge detector; one edge produces exactly one detect pulse.
REQ-016 SHALL have FSM states IDLE, ARM, COUNT and REPORT.
REQ-017 SHALL go IDLE->ARM when start=1 and gate_len!=0; start with gate_len=0 SHALL be ignored.
REQ-018 SHALL, in ARM (1 cycle), load gate_len into the gate counter, clear the edge counter and latch gate_len, lim_lo and lim_hi.
REQ-019 SHALL stay in COUNT for exactly the latched gate_len cycles and count detect pulses only in those cycles.
REQ-020 SHALL saturate the edge counter at 2^CNT_W-1 and set the internal sat flag.
REQ-021 SHALL, in REPORT (1 cycle), register count_o, in_range_o and sat_o and assert valid_o.
REQ-022 SHALL go REPORT->ARM when cont=1, and REPORT->IDLE otherwise.
REQ-023 SHALL, for start sampled at cycle t, give ARM at t+1, COUNT at t+2..t+1+N and valid_o at t+2+N.
REQ-024 SHALL ignore start while busy=1; gate_len and limit changes SHALL take effect only at the next ARM.
REQ-025 SHALL not count an edge that coincides with the last COUNT cycle and ARM of the following window into both windows; each detect pulse goes to at most one window.
REQ-026 SHALL, when lim_lo > lim_hi, drive in_range_o=0.
REQ-027 SHALL treat meas_in toggling faster than clk/2 as out of specification, with counts undefined but no lock-up.

Reset
REQ-028 SHALL, on rst_n=0, immediately force FSM=IDLE, all counters and synchronizer flops to 0, and busy, valid_o, count_o, in_range_o and sat_o to 0.
REQ-029 SHALL, on assertion mid-measurement, discard the window without a valid_o pulse; after release, wait for a new start.

Structure
REQ-030 SHALL place the state enum (IDLE/ARM/COUNT/REPORT) and the default widths in shared package clk_meas_pkg.
REQ-031 SHALL implement synchronizer plus edge detect as sub-module edge_sync (clk, rst_n, d_async, rise_pulse).
REQ-032 SHALL contain no latches and no logic clocked by meas_in.

Verification (clk period 62.5 ns, 16 MHz, timescale 1ns/1ps)
REQ-033 SHALL cover: meas_in period 8 clk cycles, gate_len=64, start -> valid_o at t+66, count_o=8, lim 7..9 gives in_range_o=1.
REQ-034 SHALL cover: meas_in=constant 0, gate_len=100 -> count_o=0, in_range_o=0 with lim 1..5, sat_o=0.
REQ-035 SHALL cover: CNT_W=3, meas_in period 4, gate_len=64 -> count_o=7, sat_o=1.
REQ-036 SHALL cover: cont=1, gate_len=32, meas_in period 4 -> valid_o every 34 cycles, count_o=8 each time, and a second start while busy is ignored.
REQ-037 SHALL cover: rst_n low at COUNT cycle 10 -> outputs 0 asynchronously, no valid_o, idle after release until start.
REQ-038 SHALL cover: start with gate_len=0 -> busy stays 0, no valid_o.
